// File: rtl/reg_verify_sequencer_if.sv
// Signal bundle between the bring-up sequencer (slave) and its surroundings: processor,
// instruction ROM, regfile read port and expected-value table (master).
interface reg_verify_sequencer_if #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned REG_COUNT       = 8,
  parameter int unsigned REG_ADDR_WIDTH  = 3,
  parameter int unsigned IMEM_ADDR_WIDTH = 8,
  parameter int unsigned CYCLE_WIDTH     = 10,
  parameter int unsigned EXP_ADDR_WIDTH  = 6,
  parameter int unsigned ERR_WIDTH       = 8
);
  logic                       start;
  logic [CYCLE_WIDTH-1:0]     num_cycles;
  logic [EXP_ADDR_WIDTH:0]    exp_count;
  logic                       stop_on_fail;
  logic [IMEM_ADDR_WIDTH-1:0] instAddr;
  logic [REG_ADDR_WIDTH-1:0]  cpu_readReg;
  logic [REG_ADDR_WIDTH-1:0]  ctrl_readReg;
  logic [DATA_WIDTH-1:0]      data_readReg;
  logic [EXP_ADDR_WIDTH-1:0]  exp_index;
  logic [REG_ADDR_WIDTH-1:0]  exp_reg;
  logic [DATA_WIDTH-1:0]      exp_value;
  logic                       test_mode;
  logic                       running;
  logic                       done;
  logic                       pass;
  logic [ERR_WIDTH-1:0]       errors;
  logic [REG_COUNT-1:0]       fail_mask;
  logic                       bad_entry;

  modport slave (
    input  start, num_cycles, exp_count, stop_on_fail, cpu_readReg, data_readReg, exp_reg,
           exp_value,
    output instAddr, ctrl_readReg, exp_index, test_mode, running, done, pass, errors,
           fail_mask, bad_entry
  );

  modport master (
    output start, num_cycles, exp_count, stop_on_fail, cpu_readReg, data_readReg, exp_reg,
           exp_value,
    input  instAddr, ctrl_readReg, exp_index, test_mode, running, done, pass, errors,
           fail_mask, bad_entry
  );
endinterface

// File: rtl/reg_verify_sequencer.sv
// Run-then-check bring-up sequencer: steps the instruction address for a cycle budget, then
// takes the regfile read port and compares it against an expected-value table.
module reg_verify_sequencer #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned REG_COUNT       = 8,
  parameter int unsigned REG_ADDR_WIDTH  = 3,
  parameter int unsigned IMEM_ADDR_WIDTH = 8,
  parameter int unsigned CYCLE_WIDTH     = 10,
  parameter int unsigned EXP_ADDR_WIDTH  = 6,
  parameter int unsigned ERR_WIDTH       = 8
) (
  input logic                   clock,
  input logic                   reset,
  reg_verify_sequencer_if.slave bus
);
  localparam int unsigned IdxWidth = EXP_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {StIdle, StRun, StFetch, StSettle, StCompare, StDone} state_e;

  state_e                     state_q, state_d;
  logic [IMEM_ADDR_WIDTH-1:0] inst_addr_q, inst_addr_d;
  logic [CYCLE_WIDTH-1:0]     cycle_cnt_q, cycle_cnt_d;
  logic [CYCLE_WIDTH-1:0]     num_cycles_q, num_cycles_d;
  // One extra bit so the index can reach a full-table exp_count.
  logic [IdxWidth-1:0]        exp_count_q, exp_count_d;
  logic [IdxWidth-1:0]        exp_idx_q, exp_idx_d;
  logic                       stop_q, stop_d;
  logic [ERR_WIDTH-1:0]       errors_q, errors_d;
  logic [REG_COUNT-1:0]       fail_mask_q, fail_mask_d;
  logic                       bad_entry_q, bad_entry_d;
  logic [REG_ADDR_WIDTH-1:0]  chk_reg_q, chk_reg_d;
  logic [DATA_WIDTH-1:0]      chk_val_q, chk_val_d;

  logic start_ok, run_last, chk_bad, chk_miss, chk_fail;
  logic test_mode, running, done, pass;

  assign start_ok = bus.start && (state_q == StIdle || state_q == StDone);
  assign run_last = (cycle_cnt_q + CYCLE_WIDTH'(1)) == num_cycles_q;
  assign chk_bad  = 32'(chk_reg_q) >= REG_COUNT;
  assign chk_miss = !chk_bad && (bus.data_readReg != chk_val_q);
  assign chk_fail = chk_bad || chk_miss;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start_ok) state_d = (bus.num_cycles == '0) ? StFetch : StRun;
      StRun:          if (run_last) state_d = StFetch;
      StFetch:        state_d = (exp_idx_q == exp_count_q) ? StDone : StSettle;
      StSettle:       state_d = StCompare;
      StCompare:      state_d = (chk_fail && stop_q) ? StDone : StFetch;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    inst_addr_d  = inst_addr_q;
    cycle_cnt_d  = cycle_cnt_q;
    num_cycles_d = num_cycles_q;
    exp_count_d  = exp_count_q;
    exp_idx_d    = exp_idx_q;
    stop_d       = stop_q;
    errors_d     = errors_q;
    fail_mask_d  = fail_mask_q;
    bad_entry_d  = bad_entry_q;
    chk_reg_d    = chk_reg_q;
    chk_val_d    = chk_val_q;
    if (start_ok) begin
      inst_addr_d  = '0;
      cycle_cnt_d  = '0;
      exp_idx_d    = '0;
      errors_d     = '0;
      fail_mask_d  = '0;
      bad_entry_d  = 1'b0;
      num_cycles_d = bus.num_cycles;
      exp_count_d  = bus.exp_count;
      stop_d       = bus.stop_on_fail;
    end else begin
      case (state_q)
        StRun: begin
          inst_addr_d = inst_addr_q + IMEM_ADDR_WIDTH'(1);
          cycle_cnt_d = cycle_cnt_q + CYCLE_WIDTH'(1);
        end
        StSettle: begin
          chk_reg_d = bus.exp_reg;
          chk_val_d = bus.exp_value;
        end
        StCompare: begin
          exp_idx_d = exp_idx_q + IdxWidth'(1);
          if (chk_bad) bad_entry_d = 1'b1;
          if (chk_fail && errors_q != '1) errors_d = errors_q + ERR_WIDTH'(1);
          if (chk_miss) begin
            for (int unsigned r = 0; r < REG_COUNT; r++) begin
              if (chk_reg_q == REG_ADDR_WIDTH'(r)) fail_mask_d[r] = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inst_addr_q  <= '0;
      cycle_cnt_q  <= '0;
      num_cycles_q <= '0;
      exp_count_q  <= '0;
      exp_idx_q    <= '0;
      stop_q       <= 1'b0;
      errors_q     <= '0;
      fail_mask_q  <= '0;
      bad_entry_q  <= 1'b0;
      chk_reg_q    <= '0;
      chk_val_q    <= '0;
    end else begin
      inst_addr_q  <= inst_addr_d;
      cycle_cnt_q  <= cycle_cnt_d;
      num_cycles_q <= num_cycles_d;
      exp_count_q  <= exp_count_d;
      exp_idx_q    <= exp_idx_d;
      stop_q       <= stop_d;
      errors_q     <= errors_d;
      fail_mask_q  <= fail_mask_d;
      bad_entry_q  <= bad_entry_d;
      chk_reg_q    <= chk_reg_d;
      chk_val_q    <= chk_val_d;
    end
  end

  always_comb begin
    test_mode = state_q inside {StFetch, StSettle, StCompare, StDone};
    running   = state_q == StRun;
    done      = state_q == StDone;
    pass      = done && (errors_q == '0) && !bad_entry_q;
  end

  assign bus.instAddr     = inst_addr_q;
  assign bus.ctrl_readReg = test_mode ? chk_reg_q : bus.cpu_readReg;
  assign bus.exp_index    = exp_idx_q[EXP_ADDR_WIDTH-1:0];
  assign bus.test_mode    = test_mode;
  assign bus.running      = running;
  assign bus.done         = done;
  assign bus.pass         = pass;
  assign bus.errors       = errors_q;
  assign bus.fail_mask    = fail_mask_q;
  assign bus.bad_entry    = bad_entry_q;
endmodule

// File: doc/reg_verify_sequencer.md
Name: reg_verify_sequencer

Overview:
Synthesizable run-then-check sequencer for processor bring-up. It sequences the instruction address for a programmed number of cycles, then takes over the regfile read port and sweeps a table of expected {register, value} entries. Mismatches are counted, and a per-register fail mask is recorded. It sits between the processor, the instruction ROM, the regfile read port and an expected-value table, which is a synchronous ROM.

Parameters:
DATA_WIDTH, 8, regfile data width
REG_COUNT, 8, number of architectural registers
REG_ADDR_WIDTH, 3, regfile address width (2^REG_ADDR_WIDTH >= REG_COUNT)
IMEM_ADDR_WIDTH, 8, instruction address width
CYCLE_WIDTH, 10, width of cycle budget
EXP_ADDR_WIDTH, 6, expected-table index width
ERR_WIDTH, 8, error counter width (saturating)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; forces IDLE and all reset values
start  in  1  launch pulse; honoured only in IDLE or DONE
num_cycles  in  CYCLE_WIDTH  run budget, sampled on accepted start
exp_count  in  EXP_ADDR_WIDTH+1  number of table entries to check, sampled on start
stop_on_fail  in  1  sampled on start; 1 = end sweep at first mismatch
instAddr  out  IMEM_ADDR_WIDTH  instruction address to ROM
cpu_readReg  in  REG_ADDR_WIDTH  processor's regfile read address
ctrl_readReg  out  REG_ADDR_WIDTH  muxed regfile read address
data_readReg  in  DATA_WIDTH  regfile combinational read data
exp_index  out  EXP_ADDR_WIDTH  table address
exp_reg  in  REG_ADDR_WIDTH  table register field, valid 1 cycle after exp_index
exp_value  in  DATA_WIDTH  table value field, same timing
test_mode  out  1  1 when sequencer owns read port
running  out  1  1 in RUN
done  out  1  1 in DONE
pass  out  1  valid when done: errors==0 and bad_entry==0
errors  out  ERR_WIDTH  mismatch count, saturates at all-ones
fail_mask  out  REG_COUNT  bit r set if register r mismatched
bad_entry  out  1  sticky: table entry had exp_reg >= REG_COUNT

Behaviour:
- Reset values: state IDLE; instAddr=0, exp_index=0, errors=0, fail_mask=0, bad_entry=0, test_mode=0, running=0, done=0, pass=0. Reset mid-run aborts immediately; there is no partial result.
- ctrl_readReg = test_mode ? chk_reg : cpu_readReg. This is combinational. test_mode=1 in FETCH, SETTLE, COMPARE and DONE.
- IDLE or DONE + start: clear instAddr, cycle count, exp_index, errors, fail_mask, bad_entry and done. Latch the inputs. Go to RUN, or to FETCH if num_cycles==0.
- RUN: each clock, instAddr += 1 (wraps modulo 2^IMEM_ADDR_WIDTH) and cycle count += 1. After exactly num_cycles RUN clocks, go to FETCH; instAddr then equals num_cycles mod 2^IMEM_ADDR_WIDTH.
- FETCH: if exp_index == exp_count, go to DONE. Otherwise drive exp_index and go to SETTLE.
- SETTLE: table output valid; latch chk_reg<=exp_reg and chk_val<=exp_value; go to COMPARE.
- COMPARE: ctrl_readReg=chk_reg; compare data_readReg with chk_val at end of cycle.
  - chk_reg >= REG_COUNT: set bad_entry and count as error; fail_mask unchanged.
  - mismatch: errors+1 (saturating) and fail_mask[chk_reg]=1.
  - Then exp_index += 1. Go to DONE if (mismatch or bad entry) and stop_on_fail; otherwise go to FETCH.
- Each check takes 3 cycles. Total latency start→done = 1 + num_cycles + 3*checked + 1.
- DONE: holds all results and test_mode=1. A start in the same cycle restarts. A start in RUN, FETCH, SETTLE or COMPARE is ignored.
- Duplicate table entries for one register are checked independently; errors counts each.

Test Plan:
- num_cycles=5, exp_count=0, start → running for 5 cycles, instAddr=5, then done=1, pass=1, errors=0 with done 7 cycles after start.
- num_cycles=3, table {r1=7, r2=0x2A}, regfile r1=7, r2=0x2A → pass=1, fail_mask=0, done 1+3+6+1=11 cycles after start. ctrl_readReg follows cpu_readReg during RUN and equals 1, then 2, in COMPARE.
- Table {r1=7, r3=9, r5=1}, regfile r3=8, stop_on_fail=0 → errors=1, fail_mask=0b00001000, pass=0, exp_index=3.
- Same stimulus with stop_on_fail=1 and r1 also wrong → DONE after first COMPARE, errors=1, fail_mask=0b00000010, exp_index=1.
- ERR_WIDTH=2, 5 mismatching entries → errors saturates at 3. Entry r7 with REG_COUNT=6 → bad_entry=1, pass=0.
- Assert reset mid-RUN at instAddr=4 → all outputs at reset values immediately (asynchronous). A fresh start then runs cleanly. num_cycles=300 with IMEM_ADDR_WIDTH=8 → instAddr ends at 44.
